// File: rtl/led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : led_sequencer                                             |
// | Brief    : Memory-mapped player of queued 4-bit LED patterns. The    |
// |            CPU pushes patterns into a FIFO and the block issues      |
// |            LED register writes every P cycles, one-shot or looping.  |
// | Options  : SEQ_IRQ_EN - sticky playback-done interrupt on IRQ        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module led_sequencer #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 16
) (
  input  logic        CLK_mips,
  input  logic        RST_n,
  input  logic        WE,
  input  logic [1:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        LED_WE,
  output logic [31:0] LED_wdata,
  output logic        IRQ
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = c_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_mem [DEPTH];
  logic [c_AW-1:0]       r_head;
  logic [c_AW-1:0]       r_tail;
  logic [c_CW-1:0]       r_count;
  logic [c_AW-1:0]       r_pidx;
  logic                  r_en;
  logic                  r_loop;
  logic                  r_ovf;
  logic [PERIOD_W-1:0]   r_period;
  logic [PERIOD_W-1:0]   r_timer;
  logic                  r_emit_loop;
  logic                  r_led_we;
  logic [3:0]            r_led_wdata;

  // Bus decode
  logic w_wr_ctrl, w_wr_per, w_push, w_wr_stat, w_flush;
  assign w_wr_ctrl = WE && (addr == 2'd0);
  assign w_wr_per  = WE && (addr == 2'd1);
  assign w_push    = WE && (addr == 2'd2);
  assign w_wr_stat = WE && (addr == 2'd3);
  assign w_flush   = w_wr_ctrl && write_data[2];

  // A CTRL write that clears EN stops playback in the same cycle it lands
  logic w_en_ok, w_loop_n, w_loop_chg;
  assign w_en_ok    = r_en && !(w_wr_ctrl && !write_data[0]);
  assign w_loop_n   = w_wr_ctrl ? write_data[1] : r_loop;
  assign w_loop_chg = w_wr_ctrl && (write_data[1] != r_loop);

  logic w_full, w_empty, w_busy, w_pop, w_push_ok;
  assign w_full    = (r_count == c_CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_pop     = (r_state == S_EMIT) && !r_emit_loop;
  assign w_push_ok = w_push && (!w_full || w_pop);

  logic [c_CW-1:0] w_count_n;
  assign w_count_n = r_count + c_CW'(w_push_ok) - c_CW'(w_pop);

  // Entries still playable after this cycle's pop; same-cycle pushes only
  // become playable once they have landed in the array
  logic w_avail;
  assign w_avail = (r_count - c_CW'(w_pop)) != '0;

  logic [c_AW-1:0] w_head_n, w_pidx_adv, w_pidx_n, w_rd_idx;
  assign w_head_n   = w_pop ? (r_head + c_AW'(1)) : r_head;
  assign w_pidx_adv = ((c_CW'(r_pidx) + c_CW'(1)) == r_count) ? '0 : (r_pidx + c_AW'(1));
  assign w_pidx_n   = (w_flush || w_loop_chg) ? '0 :
                      ((r_state == S_EMIT) && r_emit_loop) ? w_pidx_adv : r_pidx;
  assign w_rd_idx   = w_head_n + (w_loop_n ? w_pidx_n : '0);

  // Points where the next emission is decided; P=1 decides inside EMIT itself
  logic w_period_one, w_dec, w_start;
  assign w_period_one = (r_period <= PERIOD_W'(1));
  assign w_dec   = (r_state == S_IDLE) ||
                   ((r_state == S_HOLD) && (r_timer == '0)) ||
                   ((r_state == S_EMIT) && w_period_one);
  assign w_start = !w_flush && w_en_ok && w_dec && w_avail;

  // Playback FSM with registered LED strobe/data
  always_ff @(posedge CLK_mips or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_emit_loop <= 1'b0;
      r_led_we    <= 1'b0;
      r_led_wdata <= 4'h0;
    end else begin
      r_led_we <= w_start;
      if (w_start) begin
        r_led_wdata <= r_mem[w_rd_idx];
        r_emit_loop <= w_loop_n;
      end
      if (w_flush || !w_en_ok) begin
        r_state <= S_IDLE;
      end else if (w_start) begin
        r_state <= S_EMIT;
      end else begin
        unique case (r_state)
          S_EMIT: begin
            // HOLD spans P-1 cycles, deciding on the last one, so next EMIT lands P cycles later
            r_state <= w_period_one ? S_IDLE : S_HOLD;
            r_timer <= r_period - PERIOD_W'(2);
          end
          S_HOLD: begin
            if (r_timer == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_timer <= r_timer - PERIOD_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Control/period registers and sticky overflow flag
  always_ff @(posedge CLK_mips or negedge RST_n) begin
    if (!RST_n) begin
      r_en     <= 1'b0;
      r_loop   <= 1'b0;
      r_period <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= write_data[0];
        r_loop <= write_data[1];
      end
      if (w_wr_per) begin
        r_period <= write_data[PERIOD_W-1:0];
      end
      if (w_wr_stat) begin
        r_ovf <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and loop play index
  always_ff @(posedge CLK_mips or negedge RST_n) begin
    if (!RST_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pidx  <= '0;
    end else begin
      r_pidx <= w_pidx_n;
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= w_head_n;
        r_count <= w_count_n;
        if (w_push_ok) begin
          r_tail <= r_tail + c_AW'(1);
        end
      end
    end
  end

  // Pattern storage; contents are don't-care while outside the valid window
  always_ff @(posedge CLK_mips) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= write_data[3:0];
    end
  end

`ifdef SEQ_IRQ_EN
  logic r_irq;
  // Sticky done flag: last one-shot entry popped with nothing arriving behind it
  always_ff @(posedge CLK_mips or negedge RST_n) begin
    if (!RST_n) begin
      r_irq <= 1'b0;
    end else if (w_pop && !w_flush && (r_count == c_CW'(1)) && !w_push) begin
      r_irq <= 1'b1;
    end else if (w_wr_stat) begin
      r_irq <= 1'b0;
    end
  end
  assign IRQ = r_irq;
`else
  assign IRQ = 1'b0;
`endif

  // Register read mux
  always_comb begin
    read_data = 32'h0;
    unique case (addr)
      2'd0:    read_data = {29'h0, 1'b0, r_loop, r_en};
      2'd1:    read_data = 32'(r_period);
      2'd2:    read_data = 32'h0;
      default: read_data = {16'(r_count), 12'h0, w_full, w_empty, r_ovf, w_busy};
    endcase
  end

  assign LED_WE    = r_led_we;
  assign LED_wdata = {28'h0, r_led_wdata};

  logic w_unused;
  assign w_unused = ^write_data;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_led_sequencer                                          |
// | Brief    : Self-checking bench for led_sequencer: queue-based model, |
// |            directed scenarios and randomized bus traffic.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_led_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        led_we;
  logic [31:0] led_wdata;
  logic        irq;

  always #5 clk = ~clk;

  led_sequencer #(.DEPTH(DEPTH), .PERIOD_W(16)) dut (
    .CLK_mips  (clk),
    .RST_n     (rst_n),
    .WE        (we),
    .addr      (addr),
    .write_data(wd),
    .read_data (rd),
    .LED_WE    (led_we),
    .LED_wdata (led_wdata),
    .IRQ       (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Behavioural model: pattern queue plus "next pulse at cycle N" scheduling
  int        q[$];
  bit        m_en, m_loop, m_ovf, m_irq, m_busy, m_emit, m_emit_loop;
  int        m_per, m_pidx;
  longint    m_cyc, m_next_at;
  logic [3:0] m_led;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_en = 0; m_loop = 0; m_ovf = 0; m_irq = 0; m_busy = 0; m_emit = 0; m_emit_loop = 0;
    m_per = 0; m_pidx = 0; m_cyc = 0; m_next_at = 0; m_led = 4'h0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] v;
    case (a)
      2'd0:    v = {30'h0, m_loop, m_en};
      2'd1:    v = 32'(m_per);
      2'd2:    v = 32'h0;
      default: v = {16'(q.size()), 12'h0, q.size() == DEPTH, q.size() == 0, m_ovf, m_busy};
    endcase
    return v;
  endfunction

  // Advance the model by one clock using the bus inputs present before the edge
  function automatic void model_step();
    int p, size0, avail;
    bit wr_ctrl, flush, push, wst, wper, en_ok, pop, dec;
    p       = (m_per == 0) ? 1 : m_per;
    wr_ctrl = we && (addr == 2'd0);
    wper    = we && (addr == 2'd1);
    push    = we && (addr == 2'd2);
    wst     = we && (addr == 2'd3);
    flush   = wr_ctrl && wd[2];
    size0   = q.size();
    en_ok   = m_en && !(wr_ctrl && !wd[0]);
    dec     = !m_busy || (m_emit && p == 1) || (m_busy && !m_emit && m_cyc == m_next_at - 1);
    if (flush) begin
      q.delete();
      m_pidx = 0; m_busy = 0; m_emit = 0;
      m_en = wd[0]; m_loop = wd[1];
    end else begin
      pop = m_emit && !m_emit_loop;
      if (wst) begin
        m_ovf = 0;
        m_irq = 0;
      end
      if (pop) begin
        void'(q.pop_front());
`ifdef SEQ_IRQ_EN
        if (size0 == 1 && !push) m_irq = 1;
`endif
      end
      if (m_emit && m_emit_loop) m_pidx = (m_pidx + 1 == size0) ? 0 : m_pidx + 1;
      avail = q.size();
      if (push) begin
        if (size0 < DEPTH || pop) q.push_back(int'(wd[3:0]));
        else m_ovf = 1;
      end
      if (wr_ctrl) begin
        if (wd[1] != m_loop) m_pidx = 0;
        m_en = wd[0];
        m_loop = wd[1];
      end
      if (wper) m_per = int'(wd & 32'h0000_FFFF);
      if (!en_ok) begin
        m_busy = 0;
        m_emit = 0;
      end else if (dec) begin
        if (avail > 0) begin
          m_emit = 1; m_busy = 1; m_emit_loop = m_loop;
          m_led = 4'(m_loop ? q[m_pidx] : q[0]);
        end else begin
          m_emit = 0; m_busy = 0;
        end
      end else if (m_emit) begin
        m_emit = 0;
        m_next_at = m_cyc + p;
      end
    end
    m_cyc++;
  endfunction

  // Continuous comparison of DUT against model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("LED_WE", 32'(led_we), 32'(m_emit));
      check("LED_wdata", led_wdata, {28'h0, m_led});
      check("IRQ", 32'(irq), 32'(m_irq));
      check("read_data", rd, exp_rd(addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (led_we) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'h1);
  endtask

  initial begin
    int pc[$];
    int pv[$];
    int npulse;
    rst_n = 1'b0; we = 1'b0; addr = 2'd3; wd = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset LED_WE", 32'(led_we), 32'h0);
    check("reset LED_wdata", led_wdata, 32'h0);
    check("reset STATUS", rd, 32'h0000_0004);
    chk_on = 1'b1;

    // One-shot playback, P=3
    wr(2'd1, 32'd3); wr(2'd2, 32'h5); wr(2'd2, 32'hA); wr(2'd2, 32'h3); wr(2'd0, 32'h1);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (led_we) begin
        pc.push_back(i);
        pv.push_back(int'(led_wdata));
      end
    end
    check("oneshot pulse count", 32'(pc.size()), 32'd3);
    if (pc.size() >= 3) begin
      check("oneshot val0", 32'(pv[0]), 32'h5);
      check("oneshot val1", 32'(pv[1]), 32'hA);
      check("oneshot val2", 32'(pv[2]), 32'h3);
      check("oneshot gap0", 32'(pc[1] - pc[0]), 32'd3);
      check("oneshot gap1", 32'(pc[2] - pc[1]), 32'd3);
    end
    addr = 2'd3; #1;
    check("oneshot STATUS", rd, 32'h0000_0004);
`ifdef SEQ_IRQ_EN
    check("oneshot IRQ set", 32'(irq), 32'h1);
    wr(2'd3, 32'h0); #1;
    check("oneshot IRQ clear", 32'(irq), 32'h0);
`endif

    // Loop playback at P=1, then stop
    wr(2'd0, 32'h4); wr(2'd3, 32'h0); wr(2'd1, 32'h0);
    wr(2'd2, 32'h1); wr(2'd2, 32'h2); wr(2'd0, 32'h3);
    wait_pulse("loop start");
    for (int k = 0; k < 6; k++) begin
      check("loop strobe", 32'(led_we), 32'h1);
      check("loop value", led_wdata, (k % 2 == 1) ? 32'h2 : 32'h1);
      cyc();
    end
    wr(2'd0, 32'h2);
    repeat (3) cyc();
    addr = 2'd3; #1;
    check("loop stopped", 32'(led_we), 32'h0);
    check("loop frozen", led_wdata, 32'h1);
    check("loop STATUS", rd, 32'h0002_0000);

    // Overflow on a full FIFO
    wr(2'd0, 32'h4); wr(2'd3, 32'h0);
    for (int i = 0; i < 9; i++) wr(2'd2, 32'(i));
    addr = 2'd3; #1;
    check("full STATUS", rd, 32'h0008_000A);
    wr(2'd3, 32'h0); #1;
    check("ovf clear STATUS", rd, 32'h0008_0008);

    // Push while full during an EMIT cycle
    wr(2'd1, 32'h1); wr(2'd0, 32'h1);
    wait_pulse("full emit start");
    wr(2'd2, 32'hC);
    addr = 2'd3; #1;
    check("push on pop count", {16'h0, rd[31:16]}, 32'd8);
    repeat (30) cyc();
    check("drain STATUS", rd, 32'h0000_0004);
`ifdef SEQ_IRQ_EN
    check("drain IRQ", 32'(irq), 32'h1);
    wr(2'd3, 32'h0);
`endif

    // Flush mid-playback
    wr(2'd1, 32'h4); wr(2'd2, 32'h6); wr(2'd2, 32'h7); wr(2'd2, 32'h8); wr(2'd0, 32'h1);
    wait_pulse("flush test start");
    repeat (2) cyc();
    wr(2'd0, 32'h5);
    addr = 2'd3; #1;
    check("flush STATUS", rd, 32'h0000_0004);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (led_we) npulse++;
    end
    check("flush no pulses", 32'(npulse), 32'h0);

    // Asynchronous reset in the middle of HOLD
    wr(2'd1, 32'h6); wr(2'd2, 32'h9); wr(2'd2, 32'h3); wr(2'd0, 32'h1);
    wait_pulse("reset test start");
    repeat (2) cyc();
    chk_on = 1'b0;
    addr = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    check("midhold reset LED_WE", 32'(led_we), 32'h0);
    check("midhold reset LED_wdata", led_wdata, 32'h0);
    check("midhold reset STATUS", rd, 32'h0000_0004);
    check("midhold reset IRQ", 32'(irq), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_on = 1'b1;

    // Randomized bus traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        wr(2'd2, $urandom);
      end else if (r < 38) begin
        wr(2'd0, {29'h0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0)});
      end else if (r < 42) begin
        wr(2'd1, {16'($urandom), 16'($urandom_range(0, 5))});
      end else if (r < 46) begin
        wr(2'd3, $urandom);
      end else begin
        addr = 2'($urandom_range(0, 3));
        cyc();
      end
    end
    cyc();
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
